// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch and data requesters.
// Ports: clk/rst, flush; if_* fetch side; mem_* data side; bus_* to slave.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_stall,
  input  logic                  mem_req,
  input  logic                  mem_write_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [SEL_WIDTH-1:0]  mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ack,
  output logic                  mem_stall,
  output logic                  bus_en,
  output logic                  bus_write_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [SEL_WIDTH-1:0]  bus_sel,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM,
    RESP
  } state_t;

  state_t                state, state_nx;
  logic                  last_mem, last_mem_nx;
  logic                  drop, drop_nx;
  logic                  en_nx, we_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [SEL_WIDTH-1:0]  sel_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic [DATA_WIDTH-1:0] resp, resp_nx;
  logic                  if_go, pick_mem;

  // A flushed fetch may not start a new bus cycle.
  assign if_go = if_req & ~flush;
  // On a tie, the side not granted last wins.
  assign pick_mem = mem_req & (~if_go | ~last_mem);

  always_comb begin
    state_nx    = state;
    last_mem_nx = last_mem;
    drop_nx     = drop;
    en_nx       = bus_en;
    we_nx       = bus_write_en;
    addr_nx     = bus_addr;
    sel_nx      = bus_sel;
    wdata_nx    = bus_wdata;
    resp_nx     = resp;
    unique case (state)
      IDLE: begin
        drop_nx = 1'b0;
        if (pick_mem) begin
          state_nx    = BUSY_MEM;
          last_mem_nx = 1'b1;
          en_nx       = 1'b1;
          we_nx       = mem_write_en;
          addr_nx     = mem_addr;
          sel_nx      = mem_sel;
          wdata_nx    = mem_wdata;
        end else if (if_go) begin
          state_nx    = BUSY_IF;
          last_mem_nx = 1'b0;
          en_nx       = 1'b1;
          we_nx       = 1'b0;
          addr_nx     = if_addr;
          sel_nx      = '1;
          wdata_nx    = '0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        // The bus cycle always completes;
        // a flush only hides the fetch reply.
        if (state == BUSY_IF && flush)
          drop_nx = 1'b1;
        if (bus_ready) begin
          state_nx = RESP;
          en_nx    = 1'b0;
          we_nx    = 1'b0;
          resp_nx  = bus_write_en ? '0
                                  : bus_rdata;
        end
      end
      RESP: begin
        state_nx = IDLE;
        drop_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_mem     <= 1'b0;
      drop         <= 1'b0;
      bus_en       <= 1'b0;
      bus_write_en <= 1'b0;
      bus_addr     <= '0;
      bus_sel      <= '0;
      bus_wdata    <= '0;
      resp         <= '0;
    end else begin
      state        <= state_nx;
      last_mem     <= last_mem_nx;
      drop         <= drop_nx;
      bus_en       <= en_nx;
      bus_write_en <= we_nx;
      bus_addr     <= addr_nx;
      bus_sel      <= sel_nx;
      bus_wdata    <= wdata_nx;
      resp         <= resp_nx;
    end
  end

  // last_mem also names the owner of the reply.
  assign if_ack    = (state == RESP) & ~last_mem
                   & ~drop;
  assign mem_ack   = (state == RESP) & last_mem;
  assign if_rdata  = if_ack ? resp : '0;
  assign mem_rdata = mem_ack ? resp : '0;
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus, reply scoreboard and slave model.
// Ports: none; drives every mem_bus_arbiter port.
module tb_mem_bus_arbiter;

  logic        clk, rst, flush;
  logic        if_req, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_write_en;
  logic        mem_ack, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel, bus_sel;
  logic        bus_en, bus_write_en, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  logic        slave_ready, man_ready, slave_en;
  logic [31:0] slave_out, man_rdata, slave_rdata;
  int          ws;
  int          cyc;
  int          n_cmp, n_err;

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  assign bus_ready = slave_ready | man_ready;
  assign bus_rdata = slave_ready ? slave_out
                                 : man_rdata;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .if_stall(if_stall),
    .mem_req(mem_req),
    .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_stall(mem_stall),
    .bus_en(bus_en),
    .bus_write_en(bus_write_en),
    .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic at(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic m,
                      input logic [31:0] d,
                      input int c);
    exp_t e;
    e.is_mem = m;
    e.data   = d;
    e.cyc    = c;
    q.push_back(e);
  endtask

  // Slave: ready after ws wait states.
  initial begin
    int cnt;
    cnt = 0;
    slave_ready = 0;
    slave_out = 0;
    forever begin
      @(posedge clk);
      #1;
      slave_ready = 0;
      slave_out = 0;
      if (!bus_en) cnt = 0;
      else if (slave_en) begin
        if (cnt == ws) begin
          slave_ready = 1;
          slave_out = slave_rdata;
        end
        cnt++;
      end
    end
  end

  // Monitor: every ack pops one reply.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_ack || mem_ack) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: if_ack=%0b mem_ack=%0b, required none @cyc %0d",
                   if_ack, mem_ack, cyc);
        end else begin
          e = q.pop_front();
          check("ack_port", {30'd0, if_ack, mem_ack},
                e.is_mem ? 32'd1 : 32'd2);
          check("ack_rdata",
                e.is_mem ? mem_rdata : if_rdata,
                e.data);
          check("ack_cycle", cyc, e.cyc);
          check("stall_on_ack",
                {31'd0, e.is_mem ? mem_stall
                                 : if_stall},
                32'd0);
        end
      end
    end
  end

  initial begin
    int c;
    n_cmp = 0;
    n_err = 0;
    rst = 0;
    flush = 0;
    if_req = 1;
    if_addr = 32'hBFC00000;
    mem_req = 0;
    mem_write_en = 0;
    mem_addr = 0;
    mem_sel = 0;
    mem_wdata = 0;
    man_ready = 0;
    man_rdata = 0;
    slave_en = 1;
    ws = 0;
    slave_rdata = 32'h3C081234;

    // Reset state, then IF read, zero wait.
    at(3);
    @(negedge clk);
    check("rst_bus_en", {31'd0, bus_en}, 0);
    check("rst_bus_we", {31'd0, bus_write_en}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_sel", {28'd0, bus_sel}, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_if_ack", {31'd0, if_ack}, 0);
    check("rst_mem_ack", {31'd0, mem_ack}, 0);
    check("rst_if_stall", {31'd0, if_stall}, 1);
    at(4);
    c = cyc;
    rst = 1;
    push(0, 32'h3C081234, c + 2);
    at(c + 1);
    @(negedge clk);
    check("if_bus_en", {31'd0, bus_en}, 1);
    check("if_bus_addr", bus_addr, 32'hBFC00000);
    check("if_bus_sel", {28'd0, bus_sel}, 32'hF);
    check("if_bus_we", {31'd0, bus_write_en}, 0);
    at(c + 2);
    if_req = 0;
    at(c + 4);

    // MEM write, two wait states.
    c = cyc;
    ws = 2;
    slave_rdata = 32'h12345678;
    mem_req = 1;
    mem_write_en = 1;
    mem_addr = 32'h80001004;
    mem_sel = 4'b0011;
    mem_wdata = 32'hDEADBEEF;
    push(1, 32'h0, c + 4);
    for (int i = 1; i <= 3; i++) begin
      at(c + i);
      @(negedge clk);
      check("wr_bus_en", {31'd0, bus_en}, 1);
      check("wr_bus_we", {31'd0, bus_write_en}, 1);
      check("wr_bus_sel", {28'd0, bus_sel}, 32'h3);
      check("wr_bus_addr", bus_addr, 32'h80001004);
      check("wr_bus_wdata", bus_wdata, 32'hDEADBEEF);
      if (i == 2)
        check("wr_mem_stall", {31'd0, mem_stall}, 1);
    end
    at(c + 4);
    mem_req = 0;
    mem_write_en = 0;
    at(c + 6);

    // Flush in IDLE blocks grant, then flush in BUSY_IF.
    c = cyc;
    slave_rdata = 32'h24020001;
    if_req = 1;
    if_addr = 32'hBFC00100;
    flush = 1;
    push(0, 32'h24020001, c + 10);
    at(c + 1);
    flush = 0;
    @(negedge clk);
    check("flush_idle_no_grant", {31'd0, bus_en}, 0);
    at(c + 2);
    flush = 1;
    if_addr = 32'hBFC00200;
    at(c + 3);
    flush = 0;
    @(negedge clk);
    check("busy_addr_stable", bus_addr, 32'hBFC00100);
    at(c + 5);
    @(negedge clk);
    check("flush_no_ack", {31'd0, if_ack}, 0);
    check("flush_rdata0", if_rdata, 0);
    check("flush_stall", {31'd0, if_stall}, 1);
    at(c + 7);
    @(negedge clk);
    check("regrant_en", {31'd0, bus_en}, 1);
    check("regrant_addr", bus_addr, 32'hBFC00200);
    at(c + 10);
    if_req = 0;
    at(c + 12);

    // Flush in the bus_ready cycle.
    c = cyc;
    ws = 0;
    if_req = 1;
    if_addr = 32'hBFC00300;
    at(c + 1);
    flush = 1;
    at(c + 2);
    flush = 0;
    if_req = 0;
    @(negedge clk);
    check("flush_rdy_no_ack", {31'd0, if_ack}, 0);
    at(c + 4);

    // Tie and fairness: MEM, IF, MEM, IF.
    c = cyc;
    slave_rdata = 32'h11112222;
    if_req = 1;
    if_addr = 32'hBFC00004;
    mem_req = 1;
    mem_write_en = 1;
    mem_addr = 32'h80000010;
    mem_sel = 4'hF;
    mem_wdata = 32'h0000CAFE;
    push(1, 32'h0, c + 2);
    push(0, 32'h11112222, c + 5);
    push(1, 32'h0, c + 8);
    push(0, 32'h11112222, c + 11);
    at(c + 12);
    if_req = 0;
    mem_req = 0;
    mem_write_en = 0;
    at(c + 14);

    // Flush during BUSY_MEM leaves MEM alone.
    c = cyc;
    ws = 1;
    slave_rdata = 32'hA5A5F00F;
    mem_req = 1;
    mem_addr = 32'h80002000;
    push(1, 32'hA5A5F00F, c + 3);
    at(c + 1);
    flush = 1;
    at(c + 2);
    flush = 0;
    at(c + 3);
    mem_req = 0;
    at(c + 5);

    // Async reset in BUSY_MEM, late ready.
    c = cyc;
    slave_en = 0;
    mem_req = 1;
    mem_addr = 32'h80003000;
    at(c + 1);
    @(negedge clk);
    check("rb_bus_en", {31'd0, bus_en}, 1);
    at(c + 2);
    #2;
    rst = 0;
    mem_req = 0;
    #1;
    check("rst_drop_en", {31'd0, bus_en}, 0);
    at(c + 3);
    rst = 1;
    at(c + 4);
    man_ready = 1;
    man_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("late_rdy_ack", {31'd0, mem_ack}, 0);
    at(c + 5);
    man_ready = 0;
    @(negedge clk);
    check("late_rdy_ack2", {31'd0, mem_ack}, 0);
    at(c + 7);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the single shared memory bus between the instruction-fetch requester and the MEM-stage data requester. Grants one transaction at a time and drives the bus with registered address, data and byte-select. Returns read data and a one-cycle acknowledge to the granted requester. Raises per-requester stall requests that the pipeline stall logic feeds into the stage registers (IFID … MEMWB) until the access completes.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- SEL_WIDTH, 4, byte-select width (DATA_WIDTH/8)
- clk  in  1  clock; all state rises on posedge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (exception/eret); cancels a pending or in-flight IF response
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address (word read, sel all-ones)
- if_rdata  out  DATA_WIDTH  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_ack
- mem_req  in  1  data request, level, held until mem_ack
- mem_write_en  in  1  1=write, 0=read
- mem_addr  in  ADDR_WIDTH  data address
- mem_sel  in  SEL_WIDTH  byte lanes
- mem_wdata  in  DATA_WIDTH  write data
- mem_rdata  out  DATA_WIDTH  read data, valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse (reads and writes)
- mem_stall  out  1  mem_req & ~mem_ack
- bus_en  out  1  transaction active, held until bus_ready sampled
- bus_write_en  out  1  write strobe
- bus_addr  out  ADDR_WIDTH  registered address
- bus_sel  out  SEL_WIDTH  registered byte select
- bus_wdata  out  DATA_WIDTH  registered write data
- bus_rdata  in  DATA_WIDTH  read data, valid with bus_ready
- bus_ready  in  1  slave completion, single-cycle pulse

## Operation
- FSM: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE: no req → stay. Only one req → grant it. Both → grant the one not granted last (last_grant register; reset value IF, so first tie goes to MEM). if_req ignored in IDLE while flush=1.
- Grant: latch addr/sel/wdata/write_en into bus registers, bus_en=1, set last_grant, go BUSY_IF/BUSY_MEM. IF grant drives bus_sel=all-ones, bus_write_en=0, bus_wdata=0.
- BUSY_*: hold all bus outputs stable. On bus_ready=1: capture bus_rdata into response register, bus_en=0, go RESP.
- RESP: pulse ack of granted requester with registered rdata; go IDLE. Write responses return rdata=0.
- flush during BUSY_IF or in the same cycle as bus_ready: bus transaction runs to completion (never abandoned on the bus); sets drop flag; if_ack suppressed in RESP, if_rdata=0. Drop flag clears on entering IDLE.
- flush never affects MEM transactions.
- if_rdata/mem_rdata driven 0 whenever respective ack=0.
- Stall outputs combinational from req and ack; never assert when req=0.

## Timing
- Reset (rst=0, async): state IDLE, last_grant=IF, drop=0; all outputs 0 (bus_en, bus_write_en, bus_addr, bus_sel, bus_wdata, if_ack, mem_ack, rdata outputs, stalls follow reqs but acks 0).
- Reset mid-transaction: bus_en drops immediately; no ack ever issued for that transaction.
- Req seen in IDLE at cycle N → bus_en=1 in N+1. bus_ready at N+1+k (k≥0 wait states) → ack at N+2+k. Minimum 3 cycles/transaction, zero wait states.
- bus_ready while IDLE or RESP ignored.
- Requester may present a new request the cycle after its ack; arbiter samples it in the following IDLE cycle.
- Bus outputs change only on grant or completion; stable throughout BUSY_*.

## Test plan
- Reset: rst=0 with if_req=1 → all bus outputs 0, if_ack=0, if_stall=1; release rst → bus_en=1, bus_addr=if_addr one cycle later.
- IF read, zero wait: if_addr=0xBFC00000, bus_ready same cycle bus_en rises with bus_rdata=0x3C081234 → if_ack 1 cycle later, if_rdata=0x3C081234, if_stall low that cycle.
- MEM write, 2 wait states: mem_addr=0x80001004, sel=4'b0011, wdata=0xDEADBEEF → bus_write_en=1, bus_sel=0011 held 3 cycles; mem_ack=1 with mem_rdata=0 after ready.
- Tie and fairness: if_req and mem_req both held continuously → grants MEM, IF, MEM, IF; each ack 3 cycles apart with zero wait.
- Flush: flush pulse during BUSY_IF → bus completes, no if_ack; next IF req granted normally. flush during BUSY_MEM → mem_ack still issued.
- Async reset in BUSY_MEM with bus_en=1 → bus_en=0 within same cycle; late bus_ready after reset produces no ack.
